// File: rtl/riscv_store_aligner.sv
// rtl/riscv_store_aligner.sv - store request to doubleword-aligned write beats with byte strobes
//
// Purpose:
//   Holds one store request from the MEM stage and turns it into one or two
//   64-bit write beats for the data memory port. Each beat carries lane-positioned
//   data and byte strobes. Requests use a valid/ready handshake. Beats use a
//   valid/ready handshake.
//
// Configuration:
//   RISCV_STALIGN_MISALIGN_EN
//     Defined:   every address is legal. A store that crosses a doubleword
//                boundary is issued as a LO beat followed by a HI beat.
//     Undefined: only naturally aligned stores are legal. Any other store is
//                rejected with a misalign pulse and no write beat.
//
// Ports:
//   i_riscv_stalign_clk        core clock
//   i_riscv_stalign_rst        asynchronous reset, active-high
//   i_riscv_stalign_req_valid  store request valid
//   o_riscv_stalign_req_ready  idle, can accept a request
//   i_riscv_stalign_sel        00 sb, 01 sh, 10 sw, 11 sd
//   i_riscv_stalign_addr       byte address of the store
//   i_riscv_stalign_data       right-justified store data
//   o_riscv_stalign_wvalid     write beat valid
//   i_riscv_stalign_wready     memory accepts the beat
//   o_riscv_stalign_waddr      doubleword-aligned beat address
//   o_riscv_stalign_wdata      lane-positioned write data
//   o_riscv_stalign_wstrb      byte enables
//   o_riscv_stalign_done       pulse: final beat of the request accepted
//   o_riscv_stalign_misalign   pulse: request rejected as misaligned

module riscv_store_aligner #(
  parameter int ADDR_W = 64
) (
  input  logic              i_riscv_stalign_clk,
  input  logic              i_riscv_stalign_rst,
  input  logic              i_riscv_stalign_req_valid,
  output logic              o_riscv_stalign_req_ready,
  input  logic [1:0]        i_riscv_stalign_sel,
  input  logic [ADDR_W-1:0] i_riscv_stalign_addr,
  input  logic [63:0]       i_riscv_stalign_data,
  output logic              o_riscv_stalign_wvalid,
  input  logic              i_riscv_stalign_wready,
  output logic [ADDR_W-1:0] o_riscv_stalign_waddr,
  output logic [63:0]       o_riscv_stalign_wdata,
  output logic [7:0]        o_riscv_stalign_wstrb,
  output logic              o_riscv_stalign_done,
  output logic              o_riscv_stalign_misalign
);

`ifdef RISCV_STALIGN_MISALIGN_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [127:0]        lane_q, lane_d;
  logic [15:0]         strb_q, strb_d;
  logic                cross_q, cross_d;
  logic                done_q, done_d;
  logic                misalign_q, misalign_d;

  // Request decode, evaluated on the live inputs and captured on accept.
  logic [3:0]          nb_c;
  logic [2:0]          off_c;
  logic                aligned_c;
  logic                cross_c;
  logic                legal_c;
  logic [63:0]         dmask_c;
  logic [7:0]          smask_c;
  logic [127:0]        lane_c;
  logic [15:0]         strb_c;

  always_comb begin
    off_c     = i_riscv_stalign_addr[2:0];
    nb_c      = 4'd1;
    aligned_c = 1'b1;
    dmask_c   = 64'd0;
    smask_c   = 8'h00;
    case (i_riscv_stalign_sel)
      2'b00: begin
        nb_c      = 4'd1;
        aligned_c = 1'b1;
        dmask_c   = {56'd0, i_riscv_stalign_data[7:0]};
        smask_c   = 8'h01;
      end
      2'b01: begin
        nb_c      = 4'd2;
        aligned_c = (off_c[0] == 1'b0);
        dmask_c   = {48'd0, i_riscv_stalign_data[15:0]};
        smask_c   = 8'h03;
      end
      2'b10: begin
        nb_c      = 4'd4;
        aligned_c = (off_c[1:0] == 2'b00);
        dmask_c   = {32'd0, i_riscv_stalign_data[31:0]};
        smask_c   = 8'h0F;
      end
      default: begin
        nb_c      = 4'd8;
        aligned_c = (off_c == 3'b000);
        dmask_c   = i_riscv_stalign_data;
        smask_c   = 8'hFF;
      end
    endcase
    // off + nb never exceeds 15, so 4 bits hold the sum without overflow.
    cross_c = (({1'b0, off_c} + nb_c) > 4'd8);
    legal_c = MISALIGN_EN | aligned_c;
    lane_c  = {64'd0, dmask_c} << {off_c, 3'b000};
    strb_c  = {8'd0, smask_c} << off_c;
  end

  // Next-state and captured request. With the feature compiled out a crossing
  // store is never legal, so LO always finishes and HI is unreachable; with it
  // compiled in every store is legal, so ERR and misalign never occur.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    lane_d     = lane_q;
    strb_d     = strb_q;
    cross_d    = cross_q;
    done_d     = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_riscv_stalign_req_valid) begin
          base_d  = {i_riscv_stalign_addr[ADDR_W-1:3], 3'b000};
          lane_d  = lane_c;
          strb_d  = strb_c;
          cross_d = cross_c;
          state_d = legal_c ? ST_LO : ST_ERR;
        end
      end
      ST_LO: begin
        if (i_riscv_stalign_wready) begin
          if (cross_q) begin
            state_d = ST_HI;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_HI: begin
        if (i_riscv_stalign_wready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_ERR: begin
        state_d    = ST_IDLE;
        misalign_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_riscv_stalign_clk or posedge i_riscv_stalign_rst) begin
    if (i_riscv_stalign_rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      lane_q     <= '0;
      strb_q     <= '0;
      cross_q    <= 1'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      lane_q     <= lane_d;
      strb_q     <= strb_d;
      cross_q    <= cross_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
    end
  end

  // Beat outputs decode straight from the state register, so they are stable
  // while a beat waits for wready and drop to 0 the moment reset lands.
  always_comb begin
    o_riscv_stalign_wvalid = 1'b0;
    o_riscv_stalign_waddr  = '0;
    o_riscv_stalign_wdata  = 64'd0;
    o_riscv_stalign_wstrb  = 8'h00;
    case (state_q)
      ST_LO: begin
        o_riscv_stalign_wvalid = 1'b1;
        o_riscv_stalign_waddr  = base_q;
        o_riscv_stalign_wdata  = lane_q[63:0];
        o_riscv_stalign_wstrb  = strb_q[7:0];
      end
      ST_HI: begin
        o_riscv_stalign_wvalid = 1'b1;
        o_riscv_stalign_waddr  = base_q + ADDR_W'(8);
        o_riscv_stalign_wdata  = lane_q[127:64];
        o_riscv_stalign_wstrb  = strb_q[15:8];
      end
      default: begin
        o_riscv_stalign_wvalid = 1'b0;
      end
    endcase
  end

  assign o_riscv_stalign_req_ready = (state_q == ST_IDLE);
  assign o_riscv_stalign_done      = done_q;
  assign o_riscv_stalign_misalign  = misalign_q;

endmodule
